// File: rtl/dvp_pkg.sv
// Shared types for the DVP capture path: frame sequencer states, control strobes
// and AXI response codes.
package dvp_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_VS = 3'd1,
    CAPTURE = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4
  } state_e;

  // Per-cycle actions decoded from the current state and input events.
  typedef struct packed {
    logic frame_start;
    logic count_pxl;
    logic count_rsp;
    logic capture_end;
    logic short_err;
    logic drain_run;
    logic tmo_err;
    logic frame_done;
  } ctrl_t;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/dvp_edge_det.sv
// Registered rise/fall detector for already-synchronized level inputs; edges are
// reported in the cycle the new level is first seen.
module dvp_edge_det #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [W-1:0] d_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_reg <= '0;
    end else begin
      d_reg <= d;
    end
  end

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    assign rise[gi] = d[gi] & ~d_reg[gi];
    assign fall[gi] = ~d[gi] & d_reg[gi];
  end

endmodule

// File: rtl/dvp_frame_scheduler.sv
// Frame-level sequencer: gates the pixel pipeline to whole VSYNC-aligned frames,
// drains AXI write responses, ping-pongs frame buffers and raises sticky flags.
module dvp_frame_scheduler
  import dvp_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int FRAME_PXL = 19200,
  parameter int TXN_PXL   = 32,
  parameter int CNT_W     = 20,
  parameter int DRAIN_TMO = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start_i,
  input  logic              cfg_cont_i,
  input  logic [ADDR_W-1:0] cfg_buf0_base_i,
  input  logic [ADDR_W-1:0] cfg_buf1_base_i,
  input  logic              irq_clr_i,
  input  logic              vsync_i,
  input  logic              pxl_vld_i,
  input  logic              pxl_rdy_i,
  input  logic              bvalid_i,
  input  logic              bready_i,
  input  logic [1:0]        bresp_i,
  output logic              pipe_en_o,
  output logic [ADDR_W-1:0] pxl_mem_base_o,
  output logic              buf_idx_o,
  output logic              busy_o,
  output logic              frame_done_irq_o,
  output logic              err_o,
  output logic [15:0]       frame_cnt_o
);

  localparam int TMR_W = $clog2(DRAIN_TMO + 1);

  state_e            state_reg, state_next;
  ctrl_t             ctrl;
  logic              vs_rise, vs_fall;
  logic              pxl_ev, rsp_ev;
  logic [CNT_W-1:0]  pxl_cnt_reg, pxl_cnt_inc;
  logic [CNT_W-1:0]  resp_cnt_reg, resp_cnt_inc;
  logic [CNT_W-1:0]  bexp;
  logic [TMR_W-1:0]  drain_tmr_reg;
  logic              frame_full, drain_match, tmo_hit;
  logic              pipe_en_reg, buf_idx_reg, irq_reg, err_reg;
  logic [ADDR_W-1:0] base_reg;
  logic [15:0]       frame_cnt_reg;
  logic              err_set;

  dvp_edge_det #(
    .W (1)
  ) u_vs_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (vsync_i),
    .rise  (vs_rise),
    .fall  (vs_fall)
  );

  assign pxl_ev = pxl_vld_i & pxl_rdy_i;
  assign rsp_ev = bvalid_i & bready_i;

  assign pxl_cnt_inc  = pxl_cnt_reg + CNT_W'(1);
  assign resp_cnt_inc = resp_cnt_reg + CNT_W'(rsp_ev);
  // Partial trailing beats are never issued, so only whole beats are expected.
  assign bexp         = pxl_cnt_reg / CNT_W'(TXN_PXL);

  assign frame_full  = pxl_ev & (pxl_cnt_inc == CNT_W'(FRAME_PXL));
  // A response arriving in the compare cycle is counted before comparing.
  assign drain_match = (resp_cnt_inc == bexp);
  assign tmo_hit     = (drain_tmr_reg == TMR_W'(DRAIN_TMO - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (cfg_start_i) state_next = WAIT_VS;
      end
      WAIT_VS: begin
        if (!cfg_start_i)  state_next = IDLE;
        else if (vs_fall)  state_next = CAPTURE;
      end
      CAPTURE: begin
        // Dropping cfg_start_i here is deliberately ignored: frames are atomic.
        if (frame_full || vs_rise) state_next = DRAIN;
      end
      DRAIN: begin
        if (drain_match || tmo_hit) state_next = DONE;
      end
      DONE: begin
        state_next = (cfg_start_i && cfg_cont_i) ? WAIT_VS : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    ctrl = '0;
    case (state_reg)
      WAIT_VS: begin
        ctrl.frame_start = cfg_start_i & vs_fall;
      end
      CAPTURE: begin
        ctrl.count_pxl   = 1'b1;
        ctrl.count_rsp   = 1'b1;
        ctrl.capture_end = frame_full | vs_rise;
        ctrl.short_err   = vs_rise & ~frame_full;
      end
      DRAIN: begin
        ctrl.count_rsp = 1'b1;
        ctrl.drain_run = 1'b1;
        ctrl.tmo_err   = tmo_hit & ~drain_match;
      end
      DONE: begin
        ctrl.frame_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Frame counters and drain timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pxl_cnt_reg   <= '0;
      resp_cnt_reg  <= '0;
      drain_tmr_reg <= '0;
      frame_cnt_reg <= '0;
    end else begin
      if (ctrl.frame_start) begin
        pxl_cnt_reg  <= '0;
        resp_cnt_reg <= '0;
      end else begin
        if (ctrl.count_pxl && pxl_ev) pxl_cnt_reg <= pxl_cnt_inc;
        if (ctrl.count_rsp)           resp_cnt_reg <= resp_cnt_inc;
      end
      if (ctrl.capture_end)    drain_tmr_reg <= '0;
      else if (ctrl.drain_run) drain_tmr_reg <= drain_tmr_reg + TMR_W'(1);
      if (ctrl.frame_done) frame_cnt_reg <= frame_cnt_reg + 16'd1;
    end
  end

  // Pipeline gate and buffer ping-pong; the base is frozen for the whole frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_en_reg <= 1'b0;
      base_reg    <= '0;
      buf_idx_reg <= 1'b0;
    end else begin
      if (ctrl.frame_start) begin
        pipe_en_reg <= 1'b1;
        base_reg    <= buf_idx_reg ? cfg_buf1_base_i : cfg_buf0_base_i;
      end else if (ctrl.capture_end) begin
        pipe_en_reg <= 1'b0;
      end
      if (ctrl.frame_done) buf_idx_reg <= ~buf_idx_reg;
    end
  end

  assign err_set = ctrl.short_err | ctrl.tmo_err |
                   (rsp_ev & (bresp_i != AXI_RESP_OKAY));

  // Sticky flags: a set in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_reg <= 1'b0;
      err_reg <= 1'b0;
    end else begin
      irq_reg <= ctrl.frame_done | (irq_reg & ~irq_clr_i);
      err_reg <= err_set | (err_reg & ~irq_clr_i);
    end
  end

  assign pipe_en_o        = pipe_en_reg;
  assign pxl_mem_base_o   = base_reg;
  assign buf_idx_o        = buf_idx_reg;
  assign busy_o           = (state_reg != IDLE);
  assign frame_done_irq_o = irq_reg;
  assign err_o            = err_reg;
  assign frame_cnt_o      = frame_cnt_reg;

endmodule

// File: tb/tb_dvp_frame_scheduler.sv
// Randomized frame-level bench for dvp_frame_scheduler; a scaled-down frame keeps
// run time short while exercising every path of the sequencer.
module tb_dvp_frame_scheduler;

  localparam int ADDR_W    = 32;
  localparam int FRAME_PXL = 640;
  localparam int TXN_PXL   = 32;
  localparam int CNT_W     = 20;
  localparam int DRAIN_TMO = 256;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start, cont, irq_clr, vsync;
  logic              pxl_vld, pxl_rdy, bvalid, bready;
  logic [1:0]        bresp;
  logic [ADDR_W-1:0] b0, b1;
  logic              pipe_en_o, buf_idx_o, busy_o, frame_done_irq_o, err_o;
  logic [ADDR_W-1:0] pxl_mem_base_o;
  logic [15:0]       frame_cnt_o;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int exp_cnt = 0;
  bit exp_idx = 1'b0;

  dvp_frame_scheduler #(
    .ADDR_W    (ADDR_W),
    .FRAME_PXL (FRAME_PXL),
    .TXN_PXL   (TXN_PXL),
    .CNT_W     (CNT_W),
    .DRAIN_TMO (DRAIN_TMO)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cfg_start_i      (start),
    .cfg_cont_i       (cont),
    .cfg_buf0_base_i  (b0),
    .cfg_buf1_base_i  (b1),
    .irq_clr_i        (irq_clr),
    .vsync_i          (vsync),
    .pxl_vld_i        (pxl_vld),
    .pxl_rdy_i        (pxl_rdy),
    .bvalid_i         (bvalid),
    .bready_i         (bready),
    .bresp_i          (bresp),
    .pipe_en_o        (pipe_en_o),
    .pxl_mem_base_o   (pxl_mem_base_o),
    .buf_idx_o        (buf_idx_o),
    .busy_o           (busy_o),
    .frame_done_irq_o (frame_done_irq_o),
    .err_o            (err_o),
    .frame_cnt_o      (frame_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One frame: vsync pulse, random pixel/response traffic, then frame-level checks.
  task automatic run_frame(input int n_pix, input int n_resp, input int bad_idx,
                           input bit short_fr, input bit poke, input bit exp_err,
                           input bit tmo);
    int pix = 0, resp = 0, guard = 0, t_drain = 0, wait_n = 0;
    bit pe_ok = 1'b1, rose = 1'b0, rise_now, poked = 1'b0, pev, rev;
    logic [ADDR_W-1:0] exp_base;
    vsync = 1'b1;
    repeat (3) step();
    vsync = 1'b0;
    exp_base = exp_idx ? b1 : b0;
    step();
    chk("pipe_en_rise", pipe_en_o, 1);
    chk("base_latch", pxl_mem_base_o, exp_base);
    while ((pix < n_pix || resp < n_resp || (short_fr && !rose)) && guard < 20000) begin
      guard++;
      rise_now = 1'b0;
      if (short_fr && pix == n_pix && !rose) begin
        vsync = 1'b1;
        rose = 1'b1;
        rise_now = 1'b1;
      end
      pxl_vld = (pix < n_pix) && ($urandom_range(0, 3) != 0);
      pxl_rdy = ($urandom_range(0, 3) != 0);
      bvalid  = (resp < n_resp) && (resp < pix / TXN_PXL) && ($urandom_range(0, 2) != 0);
      bready  = ($urandom_range(0, 3) != 0);
      bresp   = (resp == bad_idx) ? 2'b10 : 2'b00;
      pev = pxl_vld && pxl_rdy;
      rev = bvalid && bready;
      if (pix < n_pix) pe_ok &= pipe_en_o;
      step();
      if (pev) pix++;
      if (rev) resp++;
      if (pev && pix == n_pix && !short_fr) begin
        chk("pipe_en_fall", pipe_en_o, 0);
        t_drain = cyc;
      end
      if (rise_now) begin
        chk("pipe_en_short", pipe_en_o, 0);
        chk("err_short", err_o, 1);
        t_drain = cyc;
      end
      if (poke && !poked && pix >= n_pix / 2) begin
        poked = 1'b1;
        b0 = $urandom;
        b1 = $urandom;
        start = 1'b0;
      end
    end
    pxl_vld = 1'b0;
    bvalid  = 1'b0;
    bresp   = 2'b00;
    vsync   = 1'b0;
    chk("stim_done", pix + resp, n_pix + n_resp);
    while (!frame_done_irq_o && wait_n < DRAIN_TMO + 64) begin
      step();
      wait_n++;
    end
    chk("irq_set", frame_done_irq_o, 1);
    exp_cnt = (exp_cnt + 1) & 16'hFFFF;
    exp_idx = ~exp_idx;
    chk("frame_cnt", frame_cnt_o, exp_cnt);
    chk("buf_idx", buf_idx_o, exp_idx);
    chk("err_flag", err_o, exp_err);
    chk("busy_after", busy_o, start && cont);
    chk("base_hold", pxl_mem_base_o, exp_base);
    chk("pe_during_frame", pe_ok, 1);
    if (tmo)
      chk("drain_tmo_len", (cyc - t_drain >= DRAIN_TMO) && (cyc - t_drain <= DRAIN_TMO + 2), 1);
    else
      chk("drain_in_time", (cyc - t_drain) < DRAIN_TMO, 1);
    $display("frame %0d: pix=%0d resp=%0d base=%08h err=%0b drain_cycles=%0d",
             exp_cnt, pix, resp, exp_base, err_o, cyc - t_drain);
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    chk("irq_clr", frame_done_irq_o, 0);
    chk("err_clr", err_o, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; cont = 1'b0; irq_clr = 1'b0; vsync = 1'b0;
    pxl_vld = 1'b0; pxl_rdy = 1'b0; bvalid = 1'b0; bready = 1'b0; bresp = 2'b00;
    b0 = $urandom; b1 = $urandom;
    repeat (3) step();
    chk("rst_pipe_en", pipe_en_o, 0);
    chk("rst_base", pxl_mem_base_o, 0);
    chk("rst_buf_idx", buf_idx_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_irq", frame_done_irq_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_frame_cnt", frame_cnt_o, 0);
    rst_n = 1'b1;
    step();

    // Single frame; bases and start change mid-frame and must not disturb it.
    start = 1'b1;
    run_frame(FRAME_PXL, FRAME_PXL / TXN_PXL, -1, 1'b0, 1'b1, 1'b0, 1'b0);

    // Continuous capture over three frames.
    b0 = 32'h8000_0000; b1 = 32'h8001_0000;
    start = 1'b1; cont = 1'b1;
    repeat (3) run_frame(FRAME_PXL, FRAME_PXL / TXN_PXL, -1, 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b0; cont = 1'b0;
    repeat (2) step();
    chk("idle_after_stop", busy_o, 0);

    // Short frame, then a stalled drain ending in timeout.
    start = 1'b1;
    run_frame(FRAME_PXL / 2, FRAME_PXL / 2 / TXN_PXL, -1, 1'b1, 1'b0, 1'b1, 1'b0);
    run_frame(FRAME_PXL, FRAME_PXL / TXN_PXL - 1, -1, 1'b0, 1'b0, 1'b1, 1'b1);

    // Error response on beat 5, then clear racing a new error.
    run_frame(FRAME_PXL, FRAME_PXL / TXN_PXL, 5, 1'b0, 1'b0, 1'b1, 1'b0);
    bvalid = 1'b1; bready = 1'b1; bresp = 2'b10; irq_clr = 1'b1;
    step();
    bvalid = 1'b0; bready = 1'b0; bresp = 2'b00; irq_clr = 1'b0;
    chk("err_set_wins", err_o, 1);
    chk("irq_stays_clr", frame_done_irq_o, 0);
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    chk("err_cleared", err_o, 0);

    // Asynchronous reset in the middle of a capture.
    vsync = 1'b1;
    repeat (3) step();
    vsync = 1'b0;
    step();
    pxl_vld = 1'b1; pxl_rdy = 1'b1;
    repeat (FRAME_PXL / 3) step();
    chk("pipe_en_mid", pipe_en_o, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_pipe_en", pipe_en_o, 0);
    chk("arst_base", pxl_mem_base_o, 0);
    chk("arst_buf_idx", buf_idx_o, 0);
    chk("arst_busy", busy_o, 0);
    chk("arst_frame_cnt", frame_cnt_o, 0);
    pxl_vld = 1'b0; pxl_rdy = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    exp_cnt = 0;
    exp_idx = 1'b0;
    repeat (10) step();
    chk("wait_vs_pipe_en", pipe_en_o, 0);
    chk("wait_vs_busy", busy_o, 1);
    run_frame(FRAME_PXL, FRAME_PXL / TXN_PXL, -1, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
